// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready bundle for one elastic pipeline stage.
//   in_valid/in_data/in_ready    : upstream side
//   out_valid/out_data/out_ready : downstream side
// slave  : the stage's view (consumes in_*, produces out_*).
// master : the environment's view (the opposite directions).
interface pipe_stage_elastic_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with a 2-entry skid buffer.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : squash stage contents into a bubble
//   bus (slave)   : in_valid/in_data/in_ready, out_valid/out_data/out_ready
//   occupancy     : entries held (0..2)
//   stall_cycles  : saturating count of cycles with out_valid & ~out_ready
// All outputs come from registers or decodes of the state register.
module pipe_stage_elastic #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cycles
);

  // Encodings equal the entry count so occupancy is a direct decode.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic in_ready_w;
  logic out_valid_w;
  logic acc_in;
  logic acc_out;

  assign in_ready_w  = (state_q != FULL);
  assign out_valid_w = (state_q != EMPTY);
  assign acc_in      = bus.in_valid & in_ready_w;
  assign acc_out     = out_valid_w & bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = main_q;
  assign occupancy     = state_q;
  assign stall_cycles  = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (out_valid_w && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc_in) begin
            main_d  = bus.in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc_in && acc_out) begin
            main_d = bus.in_data;
          end else if (acc_in) begin
            skid_d  = bus.in_data;
            state_d = FULL;
          end else if (acc_out) begin
            main_d  = BUBBLE_VAL;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (acc_out) begin
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Drives two stage instances with identical stimulus: one with default
// parameters, one with an all-ones bubble and a 4-bit stall counter.
// Both are compared against a queue-based model of a depth-2 FIFO.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush;

  pipe_stage_elastic_if #(.DATA_W(32)) bus0 ();
  pipe_stage_elastic_if #(.DATA_W(32)) bus1 ();

  logic [1:0]  occ0;
  logic [1:0]  occ1;
  logic [15:0] stall0;
  logic [3:0]  stall1;

  pipe_stage_elastic #(
    .DATA_W(32),
    .CNT_W (16)
  ) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus0.slave),
    .occupancy   (occ0),
    .stall_cycles(stall0)
  );

  pipe_stage_elastic #(
    .DATA_W    (32),
    .BUBBLE_VAL(32'hFFFF_FFFF),
    .CNT_W     (4)
  ) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus1.slave),
    .occupancy   (occ1),
    .stall_cycles(stall1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents plus one stall count per instance.
  logic [31:0] mq[$];
  int unsigned m_stall0 = 0;
  int unsigned m_stall1 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_data0;
    logic [31:0] e_data1;
    int unsigned occ;
    occ     = mq.size();
    e_data0 = (occ != 0) ? mq[0] : 32'h0000_0000;
    e_data1 = (occ != 0) ? mq[0] : 32'hFFFF_FFFF;
    check_eq("d0_out_valid", {31'b0, bus0.out_valid}, {31'b0, occ != 0});
    check_eq("d0_in_ready",  {31'b0, bus0.in_ready},  {31'b0, occ < 2});
    check_eq("d0_occupancy", {30'b0, occ0},           occ);
    check_eq("d0_out_data",  bus0.out_data,           e_data0);
    check_eq("d0_stall",     {16'b0, stall0},         m_stall0);
    check_eq("d1_out_valid", {31'b0, bus1.out_valid}, {31'b0, occ != 0});
    check_eq("d1_in_ready",  {31'b0, bus1.in_ready},  {31'b0, occ < 2});
    check_eq("d1_occupancy", {30'b0, occ1},           occ);
    check_eq("d1_out_data",  bus1.out_data,           e_data1);
    check_eq("d1_stall",     {28'b0, stall1},         m_stall1);
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
    int unsigned occ;
    bit ov;
    bit ir;
    rst            = r;
    flush          = f;
    bus0.in_valid  = iv;
    bus0.in_data   = d;
    bus0.out_ready = ordy;
    bus1.in_valid  = iv;
    bus1.in_data   = d;
    bus1.out_ready = ordy;
    @(posedge clk);
    occ = mq.size();
    ov  = (occ != 0);
    ir  = (occ < 2);
    if (r) begin
      mq.delete();
      m_stall0 = 0;
      m_stall1 = 0;
    end else begin
      if (ov && !ordy) begin
        if (m_stall0 < 65535) m_stall0++;
        if (m_stall1 < 15)    m_stall1++;
      end
      if (f) begin
        mq.delete();
      end else begin
        if (ov && ordy) void'(mq.pop_front());
        if (iv && ir)   mq.push_back(d);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // Reset held two cycles with junk offered upstream.
    cycle(1, 0, 1, 32'hDEAD_BEEF, 0);
    cycle(1, 0, 1, 32'hDEAD_BEEF, 0);
    check_eq("reset_stall_zero", {16'b0, stall0}, 32'd0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 32'(i), 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Backpressure: A, B fill the stage, C waits upstream until accepted.
    cycle(0, 0, 1, 32'h11, 0);
    cycle(0, 0, 1, 32'h22, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h33, 0);
    cycle(0, 0, 1, 32'h33, 1);
    cycle(0, 0, 1, 32'h33, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 1);

    // Flush from FULL while offering 0x44: it must never appear.
    cycle(0, 0, 1, 32'hA0, 0);
    cycle(0, 0, 1, 32'hB0, 0);
    cycle(0, 1, 1, 32'h44, 0);
    check_eq("flush_d1_bubble", bus1.out_data, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 32'h0, 1);

    // Stall saturation on the 4-bit counter.
    cycle(0, 0, 1, 32'h55, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 32'h0, 0);
    check_eq("sat_d1_stall15", {28'b0, stall1}, 32'd15);
    cycle(0, 0, 0, 32'h0, 1);

    // rst and flush together from FULL.
    cycle(0, 0, 1, 32'h66, 0);
    cycle(0, 0, 1, 32'h77, 0);
    cycle(1, 1, 1, 32'h88, 0);
    check_eq("rstflush_stall0", {16'b0, stall0}, 32'd0);

    // Reset mid-stream with three entries in flight.
    cycle(0, 0, 1, 32'h91, 0);
    cycle(0, 0, 1, 32'h92, 0);
    cycle(0, 0, 1, 32'h93, 0);
    cycle(1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(15) == 0),
            ($urandom_range(9) < 7), $urandom, ($urandom_range(9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, generalised successor to the fixed-width IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of the MIPS datapath.
- One pipeline stage with valid/ready handshake on both sides.
- 2-entry skid buffer: full throughput with a registered in_ready, so there is no combinational path from out_ready to in_ready.
- Flush squashes contents into a bubble; a saturating counter records downstream stall cycles.
- Instantiated between datapath stages with DATA_W sized to the bundled data and control fields.

Parameters:
DATA_W, 32, payload width in bits (whole stage bundle: data plus control fields).
BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0; all-zero makes every control field a no-op.
CNT_W, 16, width of stall_cycles counter.

Ports:
clk  in  1  clock; all state updates on posedge clk.
rst  in  1  synchronous, active-high reset.
flush  in  1  squash stage contents this cycle (branch/jump redirect).
in_valid  in  1  upstream presents in_data.
in_data  in  DATA_W  upstream payload.
in_ready  out  1  stage can accept; driven directly from state register.
out_valid  out  1  out_data holds a valid entry.
out_data  out  DATA_W  payload of the oldest entry, else BUBBLE_VAL.
out_ready  in  1  downstream accepts this cycle.
occupancy  out  2  entries held: 0, 1 or 2.
stall_cycles  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Clock and reset: one clock domain. Synchronous, active-high reset `rst`, sampled on the rising edge of `clk`.
- Storage: main register (drives out_data) and skid register; state EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
- Handshakes:
  - Accept-in = in_valid & in_ready.
  - Accept-out = out_valid & out_ready.
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
- Reset, when rst=1 at posedge:
  - state=EMPTY; out_data=BUBBLE_VAL; skid register=BUBBLE_VAL; stall_cycles=0.
  - Resulting outputs: in_ready=1, out_valid=0, occupancy=0.
  - rst overrides flush and any handshake in the same cycle; an entry in flight when rst is asserted mid-operation is discarded.
- Flush (when rst=0): priority over all handshakes.
  - Next state = EMPTY; main and skid registers = BUBBLE_VAL.
  - Any in_data offered that cycle is dropped, even though in_ready=1.
  - An out-accept in the flush cycle still counts as consumed downstream; the stage does not re-present that entry.
  - stall_cycles is not cleared by flush.
- Transitions (no rst, no flush):
  - EMPTY, accept-in: main<=in_data -> ONE. No accept-in: stay EMPTY.
  - ONE, accept-in and accept-out: main<=in_data, stay ONE (1 entry/cycle throughput).
  - ONE, accept-in only: skid<=in_data -> FULL.
  - ONE, accept-out only: main<=BUBBLE_VAL -> EMPTY.
  - ONE, neither: hold.
  - FULL, accept-out: main<=skid, skid<=BUBBLE_VAL -> ONE. in_ready=0 in FULL, so no accept-in is possible.
  - FULL, no accept-out: hold.
- Latency: an entry accepted at edge N appears on out_data/out_valid after edge N; 1 cycle minimum.
- Ordering: strict FIFO; entries are never duplicated or lost except by flush or rst.
- Data rules: out_data equals BUBBLE_VAL exactly when out_valid=0. in_data is ignored when in_valid=0.
- Stall counter: +1 per cycle with out_valid & ~out_ready (evaluated on pre-edge values); saturates at 2^CNT_W-1 and never wraps.
- Bus rule: no output depends combinationally on any input; all outputs are registers or decodes of the state register.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cycles=0.
- Streaming: out_ready=1, push 8'h01..8'h08 on consecutive cycles -> outputs 01..08 in order, one per cycle, first one cycle after accept; occupancy stays 1; stall_cycles=0.
- Backpressure: push A=32'h11, B=32'h22 with out_ready=0 -> occupancy=2, in_ready=0, C=32'h33 held upstream, stall_cycles increments each cycle. Then out_ready=1 -> A, B, C delivered in order with no loss.
- Flush: stage FULL (A,B); assert flush with in_valid=1, in_data=32'h44 -> next cycle occupancy=0, out_data=BUBBLE_VAL, and 32'h44 never appears. Repeat with BUBBLE_VAL=32'hFFFF_FFFF -> out_data=32'hFFFF_FFFF.
- Saturation: CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cycles reaches 15 and holds at 15.
- rst vs flush: rst and flush both high with stage FULL -> full reset values including stall_cycles=0. Separately, reset asserted mid-stream (3 entries in flight) -> no stale entry emerges after reset deasserts.
